// File: rtl/matmult_pkg.sv
// Shared types and sizing helpers for the SPI matrix-multiply engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package matmult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_t;

    localparam int SPI_SYNC_STAGES = 2;

    // Result width holding N products of two W-bit operands without wrap.
    function automatic int res_width(input int n, input int w);
        return 2 * w + $clog2(n);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronises one raw SPI pin into core_clk and flags its edges.
// Latency: level after 2 cycles, rise/fall pulse acted on at the 3rd edge.
// Backpressure: none; free-running sampler.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic n_rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    import matmult_pkg::*;

    logic [SPI_SYNC_STAGES-1:0] sync_q;
    logic                       edge_q;

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= {SPI_SYNC_STAGES{RST_VAL}};
            edge_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SPI_SYNC_STAGES-2:0], din};
            edge_q <= sync_q[SPI_SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SPI_SYNC_STAGES-1];
    assign rise  = level & ~edge_q;
    assign fall  = ~level & edge_q;

endmodule

// File: rtl/spi_matmult_engine.sv
// SPI-attached NxN matrix multiplier: load A,B over SPI, compute C=A*B, shift C out.
// Latency: N^3 cycles of one MAC each after the last load bit; readout bit-serial.
// Backpressure: none; host paces via cs_n/spi_clk. MATMULT_SIGNED_EN selects two's complement.
module spi_matmult_engine #(
    parameter int N = 2,
    parameter int W = 4
) (
    input  logic sys_clk,
    input  logic n_rst,
    input  logic spi_clk,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic ready,
    output logic busy
);
    import matmult_pkg::*;

    localparam int RW    = res_width(N, W);
    localparam int NN    = N * N;
    localparam int FRAME = 2 * NN * W;
    localparam int TOT   = NN * RW;
    localparam int IW    = $clog2(N);
    localparam int BCW   = $clog2(FRAME + 1);
    localparam int PW    = $clog2(TOT + 1);
    localparam logic [TOT-1:0] C_MASK = {{(TOT-RW){1'b0}}, {RW{1'b1}}};

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .sys_clk(sys_clk), .n_rst(n_rst), .din(spi_clk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .sys_clk(sys_clk), .n_rst(n_rst), .din(cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .sys_clk(sys_clk), .n_rst(n_rst), .din(mosi),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_lvl, mosi_rise, mosi_fall};

    state_t           state_q, state_d;
    logic [BCW-1:0]   bit_cnt;
    logic [FRAME-1:0] ab_sr;
    logic [IW-1:0]    i_q, j_q, k_q;
    logic [RW-1:0]    acc_q;
    logic [TOT-1:0]   c_q;
    logic [PW-1:0]    ptr_q;
    logic             rd_act_q;

    logic             last_bit, k_last, last_mac, read_done;
    logic [W-1:0]     a_el, b_el;
    logic [RW-1:0]    a_ext, b_ext, prod, acc_sum;
    logic [TOT-1:0]   c_upd;
    int               a_sh, b_sh, c_sh, rd_sh;

    assign last_bit  = sclk_rise && (bit_cnt == BCW'(FRAME - 1));
    assign k_last    = (k_q == IW'(N - 1));
    assign last_mac  = k_last && (j_q == IW'(N - 1)) && (i_q == IW'(N - 1));
    assign read_done = rd_act_q && (ptr_q == PW'(TOT));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cs_fall) state_d = LOAD;
            // The final bit wins over a simultaneous cs_n rise.
            LOAD: begin
                if (last_bit)     state_d = CALC;
                else if (cs_rise) state_d = IDLE;
            end
            CALC: if (last_mac) state_d = DONE;
            DONE: if (cs_rise && read_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame is shifted in MSB first, so A[0][0] ends up in the top bits.
    always_comb begin
        a_sh  = (2 * NN - 1 - (int'(i_q) * N + int'(k_q))) * W;
        b_sh  = (NN - 1 - (int'(k_q) * N + int'(j_q))) * W;
        c_sh  = (NN - 1 - (int'(i_q) * N + int'(j_q))) * RW;
        rd_sh = TOT - 1 - int'(ptr_q);
        a_el  = W'(ab_sr >> a_sh);
        b_el  = W'(ab_sr >> b_sh);
    end

`ifdef MATMULT_SIGNED_EN
    assign a_ext = {{(RW-W){a_el[W-1]}}, a_el};
    assign b_ext = {{(RW-W){b_el[W-1]}}, b_el};
`else
    assign a_ext = {{(RW-W){1'b0}}, a_el};
    assign b_ext = {{(RW-W){1'b0}}, b_el};
`endif

    // Low RW bits of the product are exact in both number systems.
    assign prod    = a_ext * b_ext;
    assign acc_sum = acc_q + prod;
    assign c_upd   = (c_q & ~(C_MASK << c_sh)) | ({{(TOT-RW){1'b0}}, acc_sum} << c_sh);

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt  <= '0;
            ab_sr    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            c_q      <= '0;
            ptr_q    <= '0;
            rd_act_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        acc_q   <= '0;
                    end
                end
                LOAD: begin
                    if (sclk_rise) begin
                        ab_sr   <= {ab_sr[FRAME-2:0], mosi_lvl};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                CALC: begin
                    if (k_last) begin
                        c_q   <= c_upd;
                        acc_q <= '0;
                        k_q   <= '0;
                        if (j_q == IW'(N - 1)) begin
                            j_q <= '0;
                            i_q <= (i_q == IW'(N - 1)) ? '0 : i_q + 1'b1;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end else begin
                        acc_q <= acc_sum;
                        k_q   <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    if (cs_fall) begin
                        ptr_q    <= '0;
                        rd_act_q <= 1'b1;
                    end else if (cs_rise) begin
                        rd_act_q <= 1'b0;
                    end else if (sclk_fall && rd_act_q && ptr_q != PW'(TOT)) begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state_q == CALC);
    assign ready = (state_q == DONE);

    always_comb begin
        miso = 1'b0;
        if (state_q == DONE && !cs_lvl && rd_act_q && ptr_q != PW'(TOT))
            miso = 1'(c_q >> rd_sh);
    end

endmodule

// File: tb/tb_spi_matmult_engine.sv
// Scoreboarded bench: driver loads matrices over SPI and queues expected C words,
// monitors deserialise miso and check busy length independently.
module tb_spi_matmult_engine;
    localparam int N     = 2;
    localparam int W     = 4;
    localparam int RW    = 2 * W + $clog2(N);
    localparam int NN    = N * N;
    localparam int FRAME = 2 * NN * W;

    logic sys_clk = 1'b0;
    logic n_rst   = 1'b1;
    logic spi_clk = 1'b0;
    logic cs_n    = 1'b1;
    logic mosi    = 1'b0;
    logic miso, ready, busy;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int exp_c[NN];
    int cur_a[NN];
    int cur_b[NN];
    logic [FRAME-1:0] cur_fr;

    bit rd_en     = 1'b0;
    int mon_bits  = 0;
    int mon_word  = 0;
    int bcnt      = 0;
    bit prev_busy = 1'b0;

    spi_matmult_engine #(.N(N), .W(W)) dut (
        .sys_clk(sys_clk),
        .n_rst  (n_rst),
        .spi_clk(spi_clk),
        .cs_n   (cs_n),
        .mosi   (mosi),
        .miso   (miso),
        .ready  (ready),
        .busy   (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #2;
    endtask

    function automatic int elem(input int raw);
`ifdef MATMULT_SIGNED_EN
        return (raw >= (1 << (W - 1))) ? raw - (1 << W) : raw;
`else
        return raw;
`endif
    endfunction

    // Reference: textbook matrix product, truncated to the RW-bit result field.
    task automatic prep();
        int s;
        cur_fr = '0;
        for (int e = 0; e < NN; e++) cur_fr = (cur_fr << W) | FRAME'(cur_a[e] & 15);
        for (int e = 0; e < NN; e++) cur_fr = (cur_fr << W) | FRAME'(cur_b[e] & 15);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += elem(cur_a[i*N+k]) * elem(cur_b[k*N+j]);
                exp_c[i*N+j] = s & ((1 << RW) - 1);
            end
    endtask

    task automatic randomize_mats();
        for (int e = 0; e < NN; e++) begin
            cur_a[e] = int'($urandom_range(0, 15));
            cur_b[e] = int'($urandom_range(0, 15));
        end
    endtask

    task automatic spi_load(input logic [FRAME-1:0] fr, input int nbits);
        cs_n = 1'b0;
        tick(6);
        for (int b = 0; b < nbits; b++) begin
            mosi = fr[FRAME-1-b];
            tick(5);
            spi_clk = 1'b1;
            tick(5);
            spi_clk = 1'b0;
        end
        cs_n = 1'b1;
        mosi = 1'b0;
    endtask

    task automatic spi_read(input int nbits, input bit checked);
        rd_en = checked;
        cs_n  = 1'b0;
        tick(6);
        for (int b = 0; b < nbits; b++) begin
            spi_clk = 1'b1;
            tick(5);
            spi_clk = 1'b0;
            tick(5);
        end
        cs_n  = 1'b1;
        rd_en = 1'b0;
        tick(8);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!ready && t < 300) begin
            @(posedge sys_clk);
            t++;
        end
        #2;
        chk("ready_rise", int'(ready), 1);
    endtask

    task automatic run_frame();
        prep();
        spi_load(cur_fr, FRAME);
        wait_ready();
    endtask

    task automatic full_read();
        for (int e = 0; e < NN; e++) exp_q.push_back(exp_c[e]);
        spi_read(NN * RW, 1'b1);
        chk("ready_after_read", int'(ready), 0);
    endtask

    // Output monitor: assemble RW-bit words from miso at each host sample edge.
    always @(negedge cs_n) begin
        mon_bits = 0;
        mon_word = 0;
    end

    always @(posedge spi_clk) begin
        if (rd_en && !cs_n) begin
            mon_word = (mon_word << 1) | int'(miso);
            mon_bits++;
            if (mon_bits == RW) begin
                if (exp_q.size() == 0) chk("c_unexpected", mon_word, -1);
                else chk("c_word", mon_word, exp_q.pop_front());
                mon_bits = 0;
                mon_word = 0;
            end
        end
    end

    // Busy monitor: each computation must hold busy for N^3 cycles, then ready.
    always @(negedge sys_clk) begin
        if (busy) begin
            bcnt++;
        end else if (prev_busy) begin
            if (n_rst) begin
                chk("busy_len", bcnt, N * N * N);
                chk("ready_after_calc", int'(ready), 1);
            end
            bcnt = 0;
        end
        prev_busy = busy;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        #1 n_rst = 1'b0;
        #1;
        chk("rst_miso", int'(miso), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_busy", int'(busy), 0);
        tick(3);
        n_rst = 1'b1;
        tick(3);

        // Basic product
        cur_a = '{1, 2, 3, 4};
        cur_b = '{5, 6, 7, 8};
        run_frame();
        full_read();

        // All-ones operands: largest unsigned result
        cur_a = '{15, 15, 15, 15};
        cur_b = '{15, 15, 15, 15};
        run_frame();
        full_read();

        // Aborted load, then a clean frame
        cur_a = '{1, 2, 3, 4};
        cur_b = '{5, 6, 7, 8};
        prep();
        spi_load(cur_fr, 20);
        tick(8);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(ready), 0);
        run_frame();
        full_read();

        // Partial readout keeps the result
        randomize_mats();
        run_frame();
        spi_read(10, 1'b0);
        chk("partial_ready", int'(ready), 1);
        full_read();

        // Reset during the 4th busy cycle
        randomize_mats();
        prep();
        spi_load(cur_fr, FRAME);
        t = 0;
        while (bcnt != 3 && t < 100) begin
            @(posedge sys_clk);
            t++;
        end
        chk("reset_wait", bcnt, 3);
        #2 n_rst = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(ready), 0);
        chk("midrst_miso", int'(miso), 0);
        tick(3);
        n_rst = 1'b1;
        tick(3);
        randomize_mats();
        run_frame();
        full_read();

        // Mixed-sign pattern (raw nibbles for -1,2,3,-4 and -8)
        cur_a = '{15, 2, 3, 12};
        cur_b = '{8, 8, 8, 8};
        run_frame();
        full_read();

        for (int r = 0; r < 4; r++) begin
            randomize_mats();
            run_frame();
            full_read();
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
